// File: rtl/shared_addsub_pkg.sv
// Shared add/sub scheduler: common types,
// op encodings and width helpers.
package shared_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // ID width for n requesters, never below 1 bit
  function automatic int idw_of(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_addsub_sched_if.sv
// Request/response bundle between ALU clients
// and the shared add/sub scheduler.
interface shared_addsub_sched_if
  import shared_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = idw_of(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_cout
  );

endinterface

// File: rtl/shared_addsub_core.sv
// Combinational add/sub unit; subtract is
// a + ~b + 1 with carry-out meaning no borrow.
module shared_addsub_core
  import shared_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic             cin;
  logic [WIDTH-1:0] b_eff;

  assign cin   = (op == OP_SUB);
  assign b_eff = cin ? ~b : b;

  assign {cout, sum} = {1'b0, a}
                     + {1'b0, b_eff}
                     + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/shared_addsub_sched.sv
// Round-robin arbiter sharing one add/sub unit
// among NREQ clients with a one-deep response reg.
module shared_addsub_sched
  import shared_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  shared_addsub_sched_if.slave bus
);

  localparam int IDW = idw_of(NREQ);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_hit;
  logic [IDW:0]     cand;
  logic             slot_free;
  logic             fire;
  logic [NREQ-1:0]  grant;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Scan downward so the candidate nearest ptr wins
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (bus.req_valid[cand[IDW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_id  = cand[IDW-1:0];
      end
    end
  end

  assign fire = gnt_hit && slot_free && !RESET;

  // One-hot ready on the winner, only when it fires
  always_comb begin
    grant = '0;
    if (fire)
      grant[gnt_id] = 1'b1;
  end

  assign bus.req_ready = grant;

  assign op_a   = bus.req_a[gnt_id*WIDTH +: WIDTH];
  assign op_b   = bus.req_b[gnt_id*WIDTH +: WIDTH];
  assign op_sel = bus.req_op[gnt_id];

  shared_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (op_a),
    .b    (op_b),
    .op   (op_sel),
    .sum  (sum),
    .cout (cout)
  );

  // Capture the granted result, else drain on ready
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      ptr         <= '0;
    end else if (fire) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_data_q  <= sum;
      rsp_cout_q  <= cout;
      ptr <= (gnt_id == IDW'(NREQ - 1))
           ? '0 : gnt_id + 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_shared_addsub_sched.sv
// Bench for shared_addsub_sched: directed cases
// plus random traffic against a behavioural model.
module tb_shared_addsub_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst;

  int vectors    = 0;
  int miscompares = 0;

  shared_addsub_sched_if #(
    .WIDTH (W),
    .NREQ  (N),
    .IDW   (2)
  ) bus ();

  shared_addsub_sched #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_ptr   = 0;
  bit m_valid = 0;
  int m_id    = 0;
  int m_data  = 0;
  bit m_cout  = 0;

  // Compare against the model, then advance it
  always @(negedge clk) begin
    int g;
    int av, bv, r;
    logic [N-1:0] exp_rdy;
    g = -1;
    if (!rst && (!m_valid || bus.rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.req_valid[(m_ptr + k) % N])
          g = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready),
        32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid),
        32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(bus.rsp_id), m_id);
      chk("rsp_data", 32'(bus.rsp_data), m_data);
      chk("rsp_cout", 32'(bus.rsp_cout),
          32'(m_cout));
    end
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0;
      m_data = 0; m_cout = 0;
    end else if (g >= 0) begin
      av = int'(bus.req_a[g*W +: W]);
      bv = int'(bus.req_b[g*W +: W]);
      if (bus.req_op[g]) begin
        r = av - bv;
        m_cout = (av >= bv);
      end else begin
        r = av + bv;
        m_cout = (r >= 256);
      end
      m_data  = r & 255;
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(int i, bit v, bit op,
                         logic [W-1:0] a,
                         logic [W-1:0] b);
    bus.req_valid[i]       = v;
    bus.req_op[i]          = op;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
  endtask

  task automatic chk_rsp(string n, int id,
                         int data, bit co);
    chk({n, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({n, "_id"}, 32'(bus.rsp_id), id);
    chk({n, "_data"}, 32'(bus.rsp_data), data);
    chk({n, "_cout"}, 32'(bus.rsp_cout), 32'(co));
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    cyc();
    cyc();
    at_neg();
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 0);
    rst = 1'b0;
    cyc();

    // single add on requester 1
    set_req(1, 1, 1'b0, 8'hF0, 8'h20);
    bus.rsp_ready = 1'b1;
    at_neg();
    chk("add_grant", 32'(bus.req_ready), 4'b0010);
    cyc();
    clear_reqs();
    at_neg();
    chk_rsp("add", 1, 8'h10, 1'b1);

    // two subtracts on requester 3
    set_req(3, 1, 1'b1, 8'h05, 8'h07);
    cyc();
    set_req(3, 1, 1'b1, 8'h07, 8'h05);
    at_neg();
    chk_rsp("sub1", 3, 8'hFE, 1'b0);
    chk("sub2_grant", 32'(bus.req_ready), 4'b1000);
    cyc();
    clear_reqs();
    at_neg();
    chk_rsp("sub2", 3, 8'h02, 1'b1);
    cyc();

    // all requesters valid: strict rotation
    for (int i = 0; i < N; i++)
      set_req(i, 1, 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom));
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("rr_grant", 32'(bus.req_ready),
          32'(1 << (k % N)));
      if (k > 0) begin
        chk("rr_valid", 32'(bus.rsp_valid), 1);
        chk("rr_id", 32'(bus.rsp_id), (k - 1) % N);
      end
      cyc();
    end
    clear_reqs();
    at_neg();
    chk("rr_last_id", 32'(bus.rsp_id), 3);
    cyc();

    // backpressure with requester 2 pending
    set_req(1, 1, 1'b0, 8'h33, 8'h44);
    cyc();
    clear_reqs();
    bus.rsp_ready = 1'b0;
    set_req(2, 1, 1'b1, 8'h10, 8'h01);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_grant", 32'(bus.req_ready), 0);
      chk_rsp("bp_hold", 1, 8'h77, 1'b0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    at_neg();
    chk("bp_release", 32'(bus.req_ready), 4'b0100);
    cyc();
    clear_reqs();
    at_neg();
    chk_rsp("bp_new", 2, 8'h0F, 1'b1);

    // requester 0 abandons while slot blocked
    bus.rsp_ready = 1'b0;
    set_req(0, 1, 1'b0, 8'h01, 8'h01);
    at_neg();
    chk("abandon_grant", 32'(bus.req_ready), 0);
    cyc();
    clear_reqs();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("abandon_id0",
          32'(bus.rsp_valid && bus.rsp_id == 0), 0);
      cyc();
    end
    at_neg();
    chk("abandon_idle", 32'(bus.rsp_valid), 0);

    // reset while a response is stalled
    set_req(1, 1, 1'b0, 8'h01, 8'h02);
    cyc();
    clear_reqs();
    bus.rsp_ready = 1'b0;
    at_neg();
    chk("pre_reset_valid", 32'(bus.rsp_valid), 1);
    cyc();
    rst = 1'b1;
    set_req(0, 1, 1'b0, 8'h0A, 8'h0B);
    set_req(2, 1, 1'b0, 8'h0C, 8'h0D);
    at_neg();
    chk("reset_no_grant", 32'(bus.req_ready), 0);
    cyc();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    at_neg();
    chk("post_reset_valid", 32'(bus.rsp_valid), 0);
    chk("post_reset_grant", 32'(bus.req_ready),
        4'b0001);
    cyc();
    clear_reqs();
    at_neg();
    chk_rsp("post_reset", 0, 8'h15, 1'b0);
    cyc();

    // random traffic, occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    cyc();
    cyc();
    at_neg();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
